tank_key_ctrl: RTL and testbench



---
 rtl/tank_key_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_tank_key_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_key_ctrl.sv
// Key controller: synchronises, debounces and edge-detects WIDTH active-low keys behind an Avalon-MM slave.
// Defining KEY_REPEAT_EN adds hold-to-repeat edge capture, with per-key repeat flags in register 3 bits [WIDTH+15:16].
module tank_key_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } keyState_t;

    logic [WIDTH-1:0] r_sync1, r_sync2, r_debounced, r_irqmask, r_edgecap;
    keyState_t        r_state [WIDTH];
    keyState_t        w_stateNext [WIDTH];
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [CNT_W-1:0] w_cntNext [WIDTH];
    logic [WIDTH-1:0] w_debNext, w_press, w_rptHit, w_edgeNext;
    logic [31:0]      w_rdata;
    logic             w_write;
    logic             w_unused;

    assign w_write  = chipselect & ~write_n;
    assign w_unused = &{1'b0, writedata[31:WIDTH]};

    // Entering PENDING already counts the first differing cycle, so a clean edge lands DEBOUNCE_CYCLES+2 cycles after the pin.
    always_comb begin
        w_debNext = r_debounced;
        w_press   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_stateNext[i] = r_state[i];
            w_cntNext[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    w_cntNext[i] = '0;
                    if (r_sync2[i] != r_debounced[i]) begin
                        w_stateNext[i] = ST_PENDING;
                        w_cntNext[i]   = CNT_W'(1);
                    end
                end
                ST_PENDING: begin
                    if (r_sync2[i] == r_debounced[i]) begin
                        w_stateNext[i] = ST_STABLE;
                        w_cntNext[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_stateNext[i] = ST_STABLE;
                        w_cntNext[i]   = '0;
                        w_debNext[i]   = r_sync2[i];
                        w_press[i]     = ~r_sync2[i];
                    end else begin
                        w_cntNext[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_stateNext[i] = ST_STABLE;
                    w_cntNext[i]   = '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rptCnt [WIDTH];
    logic [RPT_W-1:0] w_rptCntNext [WIDTH];
    logic [WIDTH-1:0] r_rptPhase, w_rptPhaseNext, r_rptFlag, w_rptFlagNext;

    // Phase 0 times the initial delay after a press, phase 1 the steady repeat period.
    always_comb begin
        w_rptHit       = '0;
        w_rptPhaseNext = r_rptPhase;
        w_rptFlagNext  = r_rptFlag;
        for (int i = 0; i < WIDTH; i++) begin
            w_rptCntNext[i] = r_rptCnt[i];
            if (r_debounced[i]) begin
                w_rptCntNext[i]   = '0;
                w_rptPhaseNext[i] = 1'b0;
            end else if ((!r_rptPhase[i] && r_rptCnt[i] == RPT_DELAY_LAST) ||
                         ( r_rptPhase[i] && r_rptCnt[i] == RPT_PERIOD_LAST)) begin
                w_rptHit[i]       = 1'b1;
                w_rptCntNext[i]   = '0;
                w_rptPhaseNext[i] = 1'b1;
            end else begin
                w_rptCntNext[i] = r_rptCnt[i] + RPT_W'(1);
            end
            if (w_press[i]) begin
                w_rptFlagNext[i] = 1'b0;
            end else if (w_rptHit[i]) begin
                w_rptFlagNext[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptPhase <= '0;
            r_rptFlag  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_rptCnt[i] <= '0;
            end
        end else begin
            r_rptPhase <= w_rptPhaseNext;
            r_rptFlag  <= w_rptFlagNext;
            for (int i = 0; i < WIDTH; i++) begin
                r_rptCnt[i] <= w_rptCntNext[i];
            end
        end
    end
`else
    assign w_rptHit = '0;
`endif

    // A new set is OR-ed in after the W1C clear so a colliding press is never lost.
    always_comb begin
        w_edgeNext = r_edgecap;
        if (w_write && address == 2'd3) begin
            w_edgeNext = w_edgeNext & ~writedata[WIDTH-1:0];
        end
        w_edgeNext = w_edgeNext | w_press | w_rptHit;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = ~r_debounced;
            2'd1:    w_rdata[WIDTH-1:0] = ~r_sync2;
            2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
            default: begin
                w_rdata[WIDTH-1:0] = r_edgecap;
`ifdef KEY_REPEAT_EN
                w_rdata[WIDTH+15:16] = r_rptFlag;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_debounced <= '1;
            r_irqmask   <= '0;
            r_edgecap   <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1     <= in_port;
            r_sync2     <= r_sync1;
            r_debounced <= w_debNext;
            if (w_write && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= w_edgeNext;
            readdata  <= w_rdata;
            irq       <= |(r_edgecap & r_irqmask);
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_stateNext[i];
                r_cnt[i]   <= w_cntNext[i];
            end
        end
    end

endmodule

// File: tb/tb_tank_key_ctrl.sv
// Self-checking bench for tank_key_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
// Build with KEY_REPEAT_EN defined to also exercise the key-repeat scenario.
module tb_tank_key_ctrl;

    localparam int W = 2;
    localparam int D = 4;
`ifdef KEY_REPEAT_EN
    localparam int RD = 20;
    localparam int RP = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] in_port = 2'b11;
    logic        irq;

    int n_compared = 0;
    int n_mismatched = 0;

    tank_key_ctrl #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: keys are described by how long the synchronised pin has disagreed
    // with the accepted level, and how long a key has been held down since acceptance.
    logic [W-1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_deb = 2'b11;
    logic [W-1:0] m_mask = 2'b00, m_edge = 2'b00, m_flag = 2'b00;
    int           m_run [W];
    int           m_age [W];
    logic [31:0]  m_rd = 32'd0;
    logic         m_irq = 1'b0;

    function automatic logic [31:0] read_model(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: v[W-1:0] = ~m_deb;
            2'd1: v[W-1:0] = ~m_s2;
            2'd2: v[W-1:0] = m_mask;
            default: begin
                v[W-1:0] = m_edge;
`ifdef KEY_REPEAT_EN
                v[W+15:16] = m_flag;
`endif
            end
        endcase
        return v;
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] press, rpt, newDeb, newEdge;
        logic [31:0]  rd;
        logic         wr;
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_deb = '1;
            m_mask = '0; m_edge = '0; m_flag = '0;
            m_rd = '0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
        end else begin
            wr     = chipselect && !write_n;
            rd     = read_model(address);
            press  = '0;
            rpt    = '0;
            newDeb = m_deb;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] !== m_deb[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        newDeb[i] = m_s2[i];
                        m_run[i]  = 0;
                        if (!m_s2[i]) press[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
`ifdef KEY_REPEAT_EN
                if (!m_deb[i]) begin
                    m_age[i] = m_age[i] + 1;
                    if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
                        rpt[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
`endif
            end
            m_irq   = |(m_edge & m_mask);
            newEdge = m_edge;
            if (wr && address == 2'd3) newEdge = newEdge & ~writedata[W-1:0];
            newEdge = newEdge | press | rpt;
            for (int i = 0; i < W; i++) begin
                if (press[i]) m_flag[i] = 1'b0;
                else if (rpt[i]) m_flag[i] = 1'b1;
            end
            if (wr && address == 2'd2) m_mask = writedata[W-1:0];
            m_edge = newEdge;
            m_deb  = newDeb;
            m_s2   = m_s1;
            m_s1   = in_port;
            m_rd   = rd;
        end
    end

    // Stimulus helpers only; every comparison lives in the scenario tasks.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cleanup();
        in_port = 2'b11;
        idle(D + 4);
        bus_write(2'd3, 32'h3);
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = 2'b00; address = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== 32'd0 || irq !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_hold: readdata=%h irq=%b, required 00000000 0", readdata, irq);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL reset_release c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
            if (k == 5) begin
                n_compared++;
                if (readdata !== 32'd0) begin
                    n_mismatched++;
                    $display("[TB] FAIL reset_data_early: readdata=%h, required 00000000", readdata);
                end
            end
            if (k == 7) begin
                n_compared++;
                if (readdata !== 32'h3) begin
                    n_mismatched++;
                    $display("[TB] FAIL reset_data_accept: readdata=%h, required 00000003", readdata);
                end
            end
        end
        address = 2'd3;
        @(negedge clk);
        n_compared++;
        if (readdata !== 32'h3) begin
            n_mismatched++;
            $display("[TB] FAIL reset_edgecap: readdata=%h, required 00000003", readdata);
        end
        cleanup();
    endtask

    task automatic test_clean_press();
        address = 2'd0;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL press_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
            if (k == 6 || k == 7) begin
                n_compared++;
                if (readdata !== ((k == 6) ? 32'd0 : 32'd1)) begin
                    n_mismatched++;
                    $display("[TB] FAIL press_latency c%0d: readdata=%h, required %0d", k, readdata, k - 6);
                end
            end
        end
        address = 2'd3;
        @(negedge clk);
        n_compared++;
        if (readdata !== 32'h1 || irq !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL press_edgecap: readdata=%h irq=%b, required 00000001 0", readdata, irq);
        end
        cleanup();
    endtask

    task automatic test_glitch();
        address = 2'd3;
        in_port[1] = 1'b0;
        idle(3);
        in_port[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL glitch_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
        end
        n_compared++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL glitch_edgecap: readdata=%h irq=%b, required 00000000 0", readdata, irq);
        end
        address = 2'd0;
        idle(1);
        @(negedge clk);
        n_compared++;
        if (readdata !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL glitch_data: readdata=%h, required 00000000", readdata);
        end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'h1);
        address = 2'd3;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL irq_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
        end
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL irq_assert: irq=%b, required 1", irq);
        end
        bus_write(2'd3, 32'h1);
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL irq_clear: irq=%b, required 0", irq);
        end
        in_port[0] = 1'b1;
        idle(D + 4);
        in_port[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL irq_masked c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
        end
        n_compared++;
        if (irq !== 1'b0 || readdata !== 32'h2) begin
            n_mismatched++;
            $display("[TB] FAIL irq_masked_key: readdata=%h irq=%b, required 00000002 0", readdata, irq);
        end
        cleanup();
    endtask

    task automatic test_collision();
        address = 2'd3;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL collide_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
        end
        bus_write(2'd3, 32'h1);
        @(negedge clk);
        n_compared++;
        if (readdata !== 32'h1 || irq !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL collide_set_wins: readdata=%h irq=%b, required 00000001 1", readdata, irq);
        end
        cleanup();
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int  sets, flagged;
        logic prevBit;
        sets = 0; flagged = 0; prevBit = 1'b0;
        address = 2'd3;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL repeat_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
            chipselect = 1'b0; write_n = 1'b1;
            if (readdata[0] === 1'b1 && prevBit === 1'b0) begin
                sets++;
                if (readdata[16] === 1'b1) flagged++;
                chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
            end
            prevBit = readdata[0];
            if (k == 54) in_port[0] = 1'b1;
        end
        chipselect = 1'b0; write_n = 1'b1;
        n_compared++;
        if (sets !== 6 || flagged !== 5) begin
            n_mismatched++;
            $display("[TB] FAIL repeat_count: sets=%0d flagged=%0d, required 6 5", sets, flagged);
        end
        cleanup();
    endtask
`endif

    task automatic test_random();
        int hold [W];
        for (int i = 0; i < W; i++) hold[i] = 1;
        for (int k = 1; k <= 400; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            chipselect = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 2) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            for (int i = 0; i < W; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    in_port[i] = ~in_port[i];
                    hold[i]    = $urandom_range(1, 10);
                end
            end
            @(negedge clk);
            n_compared++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_mismatched++;
                $display("[TB] FAIL random_cycle c%0d: readdata=%h irq=%b, required %h %b", k, readdata, irq, m_rd, m_irq);
            end
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_irq();
        test_collision();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
